// File: rtl/tank_game_pkg.sv
// Shared types and defaults for the two-player tank game: player life-cycle states,
// winner encoding and hitbox geometry.
package tank_game_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } player_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [9:0] TANK_HALF_DEF = 10'd16;
  localparam logic [9:0] BULLET_R_DEF  = 10'd3;

  // Screen coordinates are unsigned, so widen by one bit before subtracting.
  function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return diff[10] ? 10'(-diff) : diff[9:0];
  endfunction

endpackage

// File: rtl/hit_box_cmp.sv
// Combinational bullet-versus-tank overlap test: square tank hitbox grown by the
// bullet radius on every side.
module hit_box_cmp
  import tank_game_pkg::*;
#(
  parameter logic [9:0] TANK_HALF = TANK_HALF_DEF
) (
  input  logic [9:0] bullet_x,
  input  logic [9:0] bullet_y,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [9:0] radius,
  output logic       hit
);

  logic [9:0]  dx;
  logic [9:0]  dy;
  logic [10:0] reach;

  always_comb begin
    dx    = abs_diff10(bullet_x, tank_x);
    dy    = abs_diff10(bullet_y, tank_y);
    reach = {1'b0, TANK_HALF} + {1'b0, radius};
    hit   = ({1'b0, dx} <= reach) && ({1'b0, dy} <= reach);
  end

endmodule

// File: rtl/bullet_hit_arbiter.sv
// Once-per-frame hit detection between each bullet and the opposing tank, with
// per-player lives, post-hit invulnerability, bullet stop feedback and game-over result.
module bullet_hit_arbiter
  import tank_game_pkg::*;
#(
  parameter int unsigned LIVES         = 3,
  parameter logic [9:0]  TANK_HALF     = TANK_HALF_DEF,
  parameter logic [9:0]  BULLET_R      = BULLET_R_DEF,
  parameter logic [7:0]  INVULN_FRAMES = 8'd60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       two_players_mode,
  input  logic [9:0] b1_x,
  input  logic [9:0] b1_y,
  input  logic       b1_draw,
  input  logic [9:0] b2_x,
  input  logic [9:0] b2_y,
  input  logic       b2_draw,
  input  logic [9:0] t1_x,
  input  logic [9:0] t1_y,
  input  logic [9:0] t2_x,
  input  logic [9:0] t2_y,
  output logic       stop_bullet1,
  output logic       stop_bullet2,
  output logic [1:0] lives1,
  output logic [1:0] lives2,
  output logic       invuln1,
  output logic       invuln2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  logic          frame_clk_q;
  logic          frame_edge_q, frame_edge_d;
  logic          b1_on_t2, b2_on_t1;
  logic [1:0]    hit_on;

  // Index 0 is player 1, index 1 is player 2.
  player_state_e state_q [2];
  player_state_e state_d [2];
  logic [1:0]    lives_q [2];
  logic [1:0]    lives_d [2];
  logic [7:0]    cnt_q   [2];
  logic [7:0]    cnt_d   [2];
  logic [1:0]    invuln_q, invuln_d;
  logic [1:0]    stop_q, stop_d;
  logic          game_over_q, game_over_d;
  logic [1:0]    winner_q, winner_d;

  hit_box_cmp #(.TANK_HALF(TANK_HALF)) u_b1_t2 (
    .bullet_x (b1_x),
    .bullet_y (b1_y),
    .tank_x   (t2_x),
    .tank_y   (t2_y),
    .radius   (BULLET_R),
    .hit      (b1_on_t2)
  );

  hit_box_cmp #(.TANK_HALF(TANK_HALF)) u_b2_t1 (
    .bullet_x (b2_x),
    .bullet_y (b2_y),
    .tank_x   (t1_x),
    .tank_y   (t1_y),
    .radius   (BULLET_R),
    .hit      (b2_on_t1)
  );

  always_comb begin
    frame_edge_d = frame_clk & ~frame_clk_q;

    // Only a live, vulnerable tank can be hit; otherwise the bullet passes through.
    hit_on[0] = frame_edge_q & two_players_mode & b2_draw & b2_on_t1 &
                ~game_over_q & (state_q[0] == ALIVE);
    hit_on[1] = frame_edge_q & two_players_mode & b1_draw & b1_on_t2 &
                ~game_over_q & (state_q[1] == ALIVE);

    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      lives_d[p] = lives_q[p];
      cnt_d[p]   = cnt_q[p];
      case (state_q[p])
        ALIVE: begin
          if (hit_on[p]) begin
            lives_d[p] = lives_q[p] - 2'd1;
            cnt_d[p]   = '0;
            state_d[p] = (lives_q[p] == 2'd1) ? DEAD : INVULN;
          end
        end
        INVULN: begin
          if (frame_edge_q) begin
            if (cnt_q[p] == INVULN_FRAMES - 8'd1) begin
              state_d[p] = ALIVE;
              cnt_d[p]   = '0;
            end else begin
              cnt_d[p] = cnt_q[p] + 8'd1;
            end
          end
        end
        DEAD: begin
          state_d[p] = DEAD;
        end
        default: begin
          state_d[p] = ALIVE;
        end
      endcase
      invuln_d[p] = (state_d[p] == INVULN);
    end

    // A stop request is held until the shooter's bullet engine drops its draw flag.
    stop_d[0] = hit_on[1] | (stop_q[0] & b1_draw);
    stop_d[1] = hit_on[0] | (stop_q[1] & b2_draw);

    game_over_d = game_over_q;
    winner_d    = winner_q;
    if (!game_over_q && (state_q[0] == DEAD || state_q[1] == DEAD)) begin
      game_over_d = 1'b1;
      if (state_q[0] == DEAD && state_q[1] == DEAD) begin
        winner_d = WIN_DRAW;
      end else if (state_q[1] == DEAD) begin
        winner_d = WIN_P1;
      end else begin
        winner_d = WIN_P2;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q  <= 1'b0;
      frame_edge_q <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= ALIVE;
        lives_q[p] <= LIVES_INIT;
        cnt_q[p]   <= '0;
      end
      invuln_q    <= '0;
      stop_q      <= '0;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      frame_clk_q  <= frame_clk;
      frame_edge_q <= frame_edge_d;
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        lives_q[p] <= lives_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
      invuln_q    <= invuln_d;
      stop_q      <= stop_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign stop_bullet1 = stop_q[0];
  assign stop_bullet2 = stop_q[1];
  assign lives1       = lives_q[0];
  assign lives2       = lives_q[1];
  assign invuln1      = invuln_q[0];
  assign invuln2      = invuln_q[1];
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_bullet_hit_arbiter.sv
// Self-checking bench for bullet_hit_arbiter: a frame-level game model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bullet_hit_arbiter;

  localparam int REACH    = 16 + 3;
  localparam int INV_LEN  = 60;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       two_players_mode = 1'b0;
  logic [9:0] b1_x = '0, b1_y = '0, b2_x = '0, b2_y = '0;
  logic [9:0] t1_x = '0, t1_y = '0, t2_x = '0, t2_y = '0;
  logic       b1_draw = 1'b0, b2_draw = 1'b0;
  logic       stop_bullet1, stop_bullet2, invuln1, invuln2, game_over;
  logic [1:0] lives1, lives2, winner;

  int checks = 0;
  int failures = 0;

  // Model state: lives, frames of protection still owed, stop flags, result.
  int  m_lives  [2];
  int  m_remain [2];
  bit  m_stop   [2];
  bit  m_over;
  int  m_winner;
  bit  m_fc_last, m_edge, m_valid = 1'b0;

  bullet_hit_arbiter dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_clk        (frame_clk),
    .two_players_mode (two_players_mode),
    .b1_x             (b1_x),
    .b1_y             (b1_y),
    .b1_draw          (b1_draw),
    .b2_x             (b2_x),
    .b2_y             (b2_y),
    .b2_draw          (b2_draw),
    .t1_x             (t1_x),
    .t1_y             (t1_y),
    .t2_x             (t2_x),
    .t2_y             (t2_y),
    .stop_bullet1     (stop_bullet1),
    .stop_bullet2     (stop_bullet2),
    .lives1           (lives1),
    .lives2           (lives2),
    .invuln1          (invuln1),
    .invuln2          (invuln2),
    .game_over        (game_over),
    .winner           (winner)
  );

  always #5 Clk = ~Clk;

  function automatic bit inBox(int bx, int by, int tx, int ty);
    int dx, dy;
    dx = (bx > tx) ? bx - tx : tx - bx;
    dy = (by > ty) ? by - ty : ty - by;
    return (dx <= REACH) && (dy <= REACH);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frameEdge();
    frame_clk = 1'b1;
    tick(1);
    frame_clk = 1'b0;
    tick(1);
  endtask

  task automatic doReset();
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic applyStimulus(input int bx1, input int by1, input bit d1,
                               input int bx2, input int by2, input bit d2);
    b1_x = 10'(bx1); b1_y = 10'(by1); b1_draw = d1;
    b2_x = 10'(bx2); b2_y = 10'(by2); b2_draw = d2;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_stop1"}, int'(stop_bullet1), 0);
    checkOutput({tag, "_stop2"}, int'(stop_bullet2), 0);
    checkOutput({tag, "_lives1"}, int'(lives1), 3);
    checkOutput({tag, "_lives2"}, int'(lives2), 3);
    checkOutput({tag, "_inv1"}, int'(invuln1), 0);
    checkOutput({tag, "_inv2"}, int'(invuln2), 0);
    checkOutput({tag, "_over"}, int'(game_over), 0);
    checkOutput({tag, "_winner"}, int'(winner), 0);
  endtask

  // Game model: advances on each clock edge using the inputs the DUT samples there.
  initial begin
    bit act, h1, h2, dead0, dead1;
    forever begin
      @(posedge Clk);
      if (Reset) begin
        m_lives  = '{3, 3};
        m_remain = '{0, 0};
        m_stop   = '{0, 0};
        m_over   = 1'b0;
        m_winner = 0;
        m_fc_last = 1'b0;
        m_edge   = 1'b0;
        m_valid  = 1'b1;
      end else begin
        act = m_edge;
        m_edge = frame_clk & ~m_fc_last;
        m_fc_last = frame_clk;
        h1 = act && two_players_mode && b2_draw && inBox(b2_x, b2_y, t1_x, t1_y) &&
             !m_over && m_lives[0] > 0 && m_remain[0] == 0;
        h2 = act && two_players_mode && b1_draw && inBox(b1_x, b1_y, t2_x, t2_y) &&
             !m_over && m_lives[1] > 0 && m_remain[1] == 0;
        dead0 = (m_lives[0] == 0);
        dead1 = (m_lives[1] == 0);
        if (!m_over && (dead0 || dead1)) begin
          m_over = 1'b1;
          m_winner = (dead0 && dead1) ? 3 : (dead1 ? 1 : 2);
        end
        if (act) begin
          for (int p = 0; p < 2; p++) if (m_remain[p] > 0) m_remain[p]--;
        end
        if (h1) begin
          m_lives[0]--;
          if (m_lives[0] > 0) m_remain[0] = INV_LEN;
        end
        if (h2) begin
          m_lives[1]--;
          if (m_lives[1] > 0) m_remain[1] = INV_LEN;
        end
        m_stop[0] = h2 || (m_stop[0] && b1_draw);
        m_stop[1] = h1 || (m_stop[1] && b2_draw);
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge Clk);
      if (m_valid) begin
        checkOutput("m_stop1", int'(stop_bullet1), int'(m_stop[0]));
        checkOutput("m_stop2", int'(stop_bullet2), int'(m_stop[1]));
        checkOutput("m_lives1", int'(lives1), m_lives[0]);
        checkOutput("m_lives2", int'(lives2), m_lives[1]);
        checkOutput("m_inv1", int'(invuln1), int'(m_remain[0] > 0));
        checkOutput("m_inv2", int'(invuln2), int'(m_remain[1] > 0));
        checkOutput("m_over", int'(game_over), int'(m_over));
        checkOutput("m_winner", int'(winner), m_winner);
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    t1_x = 10'd100; t1_y = 10'd100;
    t2_x = 10'd300; t2_y = 10'd200;
    tick(3);
    Reset = 1'b0;
    tick(1);
    checkResetValues("reset");

    // Hitbox boundary: dx = 20 misses, dx = 19 hits.
    two_players_mode = 1'b1;
    applyStimulus(280, 200, 1, 600, 400, 0);
    frameEdge();
    checkOutput("edge20_lives2", int'(lives2), 3);
    checkOutput("edge20_stop1", int'(stop_bullet1), 0);
    applyStimulus(281, 200, 1, 600, 400, 0);
    frameEdge();
    checkOutput("edge19_stop1", int'(stop_bullet1), 1);
    checkOutput("edge19_lives2", int'(lives2), 2);
    checkOutput("edge19_inv2", int'(invuln2), 1);
    b1_draw = 1'b0;
    tick(1);
    checkOutput("edge19_stop1_clr", int'(stop_bullet1), 0);

    // Basic hit, hold, release, then invulnerability window.
    doReset();
    t2_x = 10'd310; t2_y = 10'd205;
    applyStimulus(300, 200, 1, 600, 400, 0);
    frameEdge();
    checkOutput("hit_stop1", int'(stop_bullet1), 1);
    checkOutput("hit_lives2", int'(lives2), 2);
    checkOutput("hit_inv2", int'(invuln2), 1);
    checkOutput("hit_lives1", int'(lives1), 3);
    tick(1);
    checkOutput("hold_stop1", int'(stop_bullet1), 1);
    b1_draw = 1'b0;
    tick(1);
    checkOutput("release_stop1", int'(stop_bullet1), 0);
    repeat (10) frameEdge();
    b1_draw = 1'b1;
    frameEdge();
    checkOutput("inv_hit_lives2", int'(lives2), 2);
    checkOutput("inv_hit_stop1", int'(stop_bullet1), 0);
    b1_draw = 1'b0;
    repeat (48) frameEdge();
    checkOutput("inv_frame59", int'(invuln2), 1);
    frameEdge();
    checkOutput("inv_frame60", int'(invuln2), 0);
    b1_draw = 1'b1;
    frameEdge();
    checkOutput("rehit_lives2", int'(lives2), 1);
    checkOutput("rehit_stop1", int'(stop_bullet1), 1);
    b1_draw = 1'b0;
    tick(1);

    // Bullet 1 sitting on its own tank.
    t2_x = 10'd500; t2_y = 10'd400;
    applyStimulus(100, 100, 1, 600, 400, 0);
    frameEdge();
    checkOutput("self_lives1", int'(lives1), 3);
    checkOutput("self_stop1", int'(stop_bullet1), 0);
    checkOutput("self_inv1", int'(invuln1), 0);
    b1_draw = 1'b0;

    // Both players trade hits down to zero on the same frames.
    doReset();
    t2_x = 10'd300; t2_y = 10'd200;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(300, 200, 1, 100, 100, 1);
      frameEdge();
      checkOutput("dual_stop1", int'(stop_bullet1), 1);
      checkOutput("dual_stop2", int'(stop_bullet2), 1);
      checkOutput("dual_lives1", int'(lives1), 2 - k);
      checkOutput("dual_lives2", int'(lives2), 2 - k);
      if (k < 2) begin
        b1_draw = 1'b0; b2_draw = 1'b0;
        repeat (INV_LEN) frameEdge();
      end
    end
    checkOutput("dual_over_lag", int'(game_over), 0);
    tick(1);
    checkOutput("dual_over", int'(game_over), 1);
    checkOutput("dual_winner", int'(winner), 3);
    b1_draw = 1'b0; b2_draw = 1'b0;
    tick(1);
    applyStimulus(300, 200, 1, 100, 100, 1);
    frameEdge();
    checkOutput("post_over_stop1", int'(stop_bullet1), 0);
    checkOutput("post_over_stop2", int'(stop_bullet2), 0);
    checkOutput("post_over_winner", int'(winner), 3);

    // Single-sided wins: victim 0 is player 1, victim 1 is player 2.
    for (int v = 0; v < 2; v++) begin
      doReset();
      for (int k = 0; k < 3; k++) begin
        applyStimulus(300, 200, v == 1, 100, 100, v == 0);
        frameEdge();
        b1_draw = 1'b0; b2_draw = 1'b0;
        repeat (INV_LEN + 1) frameEdge();
      end
      checkOutput("solo_over", int'(game_over), 1);
      checkOutput("solo_winner", int'(winner), (v == 0) ? 2 : 1);
      checkOutput("solo_victim_lives", (v == 0) ? int'(lives1) : int'(lives2), 0);
      checkOutput("solo_other_lives", (v == 0) ? int'(lives2) : int'(lives1), 3);
    end

    // Single-player mode ignores hits; Reset aborts a held stop.
    doReset();
    two_players_mode = 1'b0;
    applyStimulus(300, 200, 1, 600, 400, 0);
    frameEdge();
    checkOutput("mode0_lives2", int'(lives2), 3);
    checkOutput("mode0_stop1", int'(stop_bullet1), 0);
    two_players_mode = 1'b1;
    frameEdge();
    checkOutput("mode1_stop1", int'(stop_bullet1), 1);
    checkOutput("mode1_lives2", int'(lives2), 2);
    Reset = 1'b1;
    tick(1);
    checkResetValues("midhold");
    Reset = 1'b0;
    b1_draw = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
